wb_stage_regfile: RTL
=====================

// Module: wb_stage_regfile
// PURPOSE
//  Write-back end of the MEM/WB interface: consumes MEM/WB register outputs, selects write-back data,
//  commits it to the 32x32 GPR file and serves the two ID-stage read ports. Internal write-through
//  bypass lets a read in the same cycle as a write see the new value. Also holds a one-entry
//  "last retired write" buffer for EX forwarding, and counts committed register writes.
// PARAMETERS
//  DATA_W   32  data path width
//  ADDR_W   5   register address width
//  NREGS    32  number of GPRs (2**ADDR_W); register 0 hardwired to zero
//  CNT_W    32  width of retired-write counter
// PORTS
//  clk                 in   1       clock, rising edge
//  reset               in   1       asynchronous, active-low
//  regwrite_mem_wb     in   1       write-back enable from MEM/WB
//  MemtoReg_mem_wb     in   1       1: write read_data_mem_wb, 0: write result_mem_wb
//  read_data_mem_wb    in   DATA_W  load data from MEM/WB
//  result_mem_wb       in   DATA_W  ALU result from MEM/WB
//  Reg_dest_op_mem_wb  in   ADDR_W  destination register
//  rs_addr, rt_addr    in   ADDR_W  ID-stage read addresses
//  rs_data, rt_data    out  DATA_W  read data (combinational, bypassed)
//  wb_data             out  DATA_W  selected write-back value (combinational, to forwarding unit)
//  wb_en               out  1       regwrite_mem_wb && dest != 0 (combinational)
//  last_wb_valid       out  1       registered: a write retired last cycle
//  last_wb_dest        out  ADDR_W  registered destination of that write
//  last_wb_data        out  DATA_W  registered data of that write
//  retire_count        out  CNT_W   number of committed GPR writes since reset
// BEHAVIOUR
//  - Reset (reset==0, async): all NREGS registers, last_wb_*, retire_count -> 0. Held while low;
//    writes presented during reset are discarded. Combinational outputs follow inputs throughout.
//  - wb_data = MemtoReg_mem_wb ? read_data_mem_wb : result_mem_wb.
//  - wb_en = regwrite_mem_wb && (Reg_dest_op_mem_wb != 0). Writes to R0 ignored: no state change,
//    no count, last_wb_valid <= 0.
//  - Commit: on rising clk with wb_en, GPR[dest] <= wb_data; 1-cycle write latency.
//  - Reads: addr==0 -> 0. Else if wb_en && addr==dest -> wb_data (bypass). Else GPR[addr].
//    rs and rt independent; both may hit the bypass in the same cycle.
//  - last_wb buffer: every rising clk: last_wb_valid <= wb_en; when wb_en, last_wb_dest/data
//    loaded, else dest/data hold previous values.
//  - retire_count increments by 1 per committed write; wraps 2**CNT_W-1 -> 0, no saturation.
//  - No stall input: MEM/WB already inserts bubbles as regwrite=0; block never back-pressures.
//  - Reset deasserted mid-stream: first edge after release commits normally; no warm-up cycle.
// STRUCTURE
//  - Shared package mips_pkg: DATA_W, ADDR_W, NREGS, REG_ZERO ('0) constants; no local copies.
//  - One sub-module: regfile_2r1w (storage array, async reset, 2 comb read ports, 1 sync write
//    port, R0 forced zero). Top adds wb mux, bypass, last_wb buffer and counter.
// TESTING
//  1 Reset: drive writes while reset=0 -> all reads 0, retire_count 0, last_wb_valid 0.
//  2 ALU write: regwrite=1, MemtoReg=0, result=32'hDEADBEEF, dest=5; rs_addr=5 same cycle ->
//    rs_data=DEADBEEF (bypass); next cycle regwrite=0 -> rs_data still DEADBEEF, count=1.
//  3 Load write: MemtoReg=1, read_data=32'h1234_5678, result=32'hFFFF_FFFF, dest=31 ->
//    GPR31=12345678; last_wb_valid=1, dest=31, data=12345678 one cycle later.
//  4 R0: regwrite=1, dest=0, data=32'hA5A5A5A5 -> rs_addr=0 reads 0, wb_en=0, count unchanged.
//  5 Dual bypass: dest=7 write 32'h77, rs=rt=7 -> both 32'h77; back-to-back writes to 7 (1,2)
//    -> reads track 1 then 2, last_wb_data=1 then 2.
//  6 Async reset mid-stream: pull reset low between edges after 3 writes -> all regs, count,
//    last_wb_* 0 immediately, without a clock edge; count wrap checked with CNT_W=4 (15->0).

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg : shared datapath constants and types for the MIPS core |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage
`default_nettype wire

// File: rtl/wb_stage_regfile_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_stage_regfile_if : MEM/WB write-back and ID read-port bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface wb_stage_regfile_if
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic              regwrite_mem_wb;
  logic              MemtoReg_mem_wb;
  word_t             read_data_mem_wb;
  word_t             result_mem_wb;
  reg_addr_t         Reg_dest_op_mem_wb;
  reg_addr_t         rs_addr;
  reg_addr_t         rt_addr;
  word_t             rs_data;
  word_t             rt_data;
  word_t             wb_data;
  logic              wb_en;
  logic              last_wb_valid;
  reg_addr_t         last_wb_dest;
  word_t             last_wb_data;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output regwrite_mem_wb, MemtoReg_mem_wb, read_data_mem_wb, result_mem_wb,
           Reg_dest_op_mem_wb, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_en, last_wb_valid, last_wb_dest,
           last_wb_data, retire_count
  );

  modport slave (
    input  regwrite_mem_wb, MemtoReg_mem_wb, read_data_mem_wb, result_mem_wb,
           Reg_dest_op_mem_wb, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_en, last_wb_valid, last_wb_dest,
           last_wb_data, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_2r1w : GPR array, 2 async read ports, 1 sync write port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  reg_addr_t raddr_a_i,
  output word_t     rdata_a_o,
  input  reg_addr_t raddr_b_i,
  output word_t     rdata_b_o
);
  word_t mem_q [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // R0 is forced on the read side so the array never needs a special write guard downstream
  assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : mem_q[raddr_b_i];
endmodule
`default_nettype wire

// File: rtl/wb_stage_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_stage_regfile : write-back mux, bypassed GPR reads, last-write |
// | buffer and retired-write counter.                Rev 1.0          |
// +------------------------------------------------------------------+
module wb_stage_regfile
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic               clk,
  input  logic               reset,
  wb_stage_regfile_if.slave  bus
);
  word_t            wb_data;
  logic             wb_en;
  word_t            rf_rs_data;
  word_t            rf_rt_data;

  logic             last_wb_valid_q;
  reg_addr_t        last_wb_dest_q;
  reg_addr_t        last_wb_dest_d;
  word_t            last_wb_data_q;
  word_t            last_wb_data_d;
  logic [CNT_W-1:0] retire_count_q;
  logic [CNT_W-1:0] retire_count_d;

  assign wb_data = bus.MemtoReg_mem_wb ? bus.read_data_mem_wb : bus.result_mem_wb;
  assign wb_en   = bus.regwrite_mem_wb && (bus.Reg_dest_op_mem_wb != REG_ZERO);

  regfile_2r1w u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wb_en),
    .waddr_i   (bus.Reg_dest_op_mem_wb),
    .wdata_i   (wb_data),
    .raddr_a_i (bus.rs_addr),
    .rdata_a_o (rf_rs_data),
    .raddr_b_i (bus.rt_addr),
    .rdata_b_o (rf_rt_data)
  );

  // Write-through: a read in the commit cycle sees the value being written
  always_comb begin
    bus.rs_data = rf_rs_data;
    bus.rt_data = rf_rt_data;
    if (bus.rs_addr == REG_ZERO) begin
      bus.rs_data = '0;
    end else if (wb_en && (bus.rs_addr == bus.Reg_dest_op_mem_wb)) begin
      bus.rs_data = wb_data;
    end
    if (bus.rt_addr == REG_ZERO) begin
      bus.rt_data = '0;
    end else if (wb_en && (bus.rt_addr == bus.Reg_dest_op_mem_wb)) begin
      bus.rt_data = wb_data;
    end
  end

  assign last_wb_dest_d = wb_en ? bus.Reg_dest_op_mem_wb : last_wb_dest_q;
  assign last_wb_data_d = wb_en ? wb_data : last_wb_data_q;
  assign retire_count_d = wb_en ? retire_count_q + CNT_W'(1) : retire_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_wb_valid_q <= 1'b0;
      last_wb_dest_q  <= '0;
      last_wb_data_q  <= '0;
      retire_count_q  <= '0;
    end else begin
      last_wb_valid_q <= wb_en;
      last_wb_dest_q  <= last_wb_dest_d;
      last_wb_data_q  <= last_wb_data_d;
      retire_count_q  <= retire_count_d;
    end
  end

  assign bus.wb_data       = wb_data;
  assign bus.wb_en         = wb_en;
  assign bus.last_wb_valid = last_wb_valid_q;
  assign bus.last_wb_dest  = last_wb_dest_q;
  assign bus.last_wb_data  = last_wb_data_q;
  assign bus.retire_count  = retire_count_q;
endmodule
`default_nettype wire
